updater_cmd_queue: RTL
======================

Name: updater_cmd_queue

Overview:
Command queue and dispatcher upstream of the octree Updater. It buffers anchor add/delete requests and their per-anchor feature beats. It issues requests to the Updater one at a time, in order, using the Updater's pulse-start / stream / done protocol. It decouples the scene-management producer from the Updater's variable SRAM-bound latency.

Parameters:
DATA_BUS_WIDTH, 64, feature beat width (matches Updater feature_in)
ENCODE_ADDR_WIDTH, 18, anchor position code width (LOG_CHILD_NUM*TREE_LEVEL+LOG_TREE_LEVEL)
FEATURE_LENTH, 9, feature beats per add request
CMD_DEPTH, 4, command FIFO entries; power of two, >=2
FEAT_DEPTH, 36, feature FIFO entries; must be >= FEATURE_LENTH; default CMD_DEPTH*FEATURE_LENTH

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
cmd_valid  in  1  producer command valid
cmd_ready  out  1  command FIFO not full
cmd_op  in  1  1 = add anchor, 0 = delete anchor
cmd_pos  in  ENCODE_ADDR_WIDTH  anchor position code
feat_valid  in  1  producer feature beat valid
feat_ready  out  1  feature FIFO not full
feat_data  in  DATA_BUS_WIDTH  feature beat
add_anchor  out  1  one-cycle start pulse to Updater (add)
del_anchor  out  1  one-cycle start pulse to Updater (delete)
pos_encode  out  ENCODE_ADDR_WIDTH  position code to Updater
feature_in  out  DATA_BUS_WIDTH  feature beat to Updater
add_done  in  1  Updater add complete
del_done  in  1  Updater delete complete
busy  out  1  dispatcher not in IDLE
q_level  out  $clog2(CMD_DEPTH+1)  commands held in FIFO (excluding the one in flight)
proto_err  out  1  sticky: unexpected done seen

Behaviour:
- Reset: all outputs 0; cmd_ready and feat_ready are 0 while rst is high and 1 from the first cycle after release; both FIFOs empty; state IDLE; proto_err cleared.
- Command FIFO: push when cmd_valid&&cmd_ready; cmd_ready = !full (no bypass, so a pop in the same cycle does not admit a push when full). Stores {op,pos}.
- Feature FIFO: push when feat_valid&&feat_ready; feat_ready = !full. Delete commands consume no beats. The producer supplies exactly FEATURE_LENTH beats per add, in command order.
- Registered FIFOs: a command accepted in cycle N can dispatch at the earliest in cycle N+1.
- IDLE: the head command dispatches if the command FIFO is non-empty and either (op=0) or (op=1 and feature occupancy >= FEATURE_LENTH). Otherwise wait; no reordering; a starved add blocks the deletes behind it.
- Delete dispatch: del_anchor=1 for one cycle; pos_encode=head pos; pop command; go to WAIT_DEL.
- Add dispatch: add_anchor=1 for one cycle; feature_in=beat 0 in the same cycle; pop command and beat; beat counter=1; go to ADD_STREAM.
- ADD_STREAM: each cycle present the next beat on feature_in and pop it. After beat FEATURE_LENTH-1 (8 cycles after the pulse), go to WAIT_ADD. Beats are guaranteed present, so there are no bubbles.
- WAIT_ADD: exit to IDLE on add_done. WAIT_DEL: exit to IDLE on del_done.
- Back-to-back: the next dispatch can occur in the cycle after done, giving a minimum 1-cycle gap.
- pos_encode: held stable from dispatch until done; it holds its last value in IDLE.
- feature_in: 0 outside the cycles of the add pulse and ADD_STREAM.
- proto_err: set when add_done or del_done arrives in any state other than its matching WAIT state, or both arrive in the same cycle. The offending done is ignored; proto_err is cleared only by rst.
- busy: 1 in ADD_STREAM, WAIT_ADD, and WAIT_DEL.
- q_level: registered count; push+pop in the same cycle leaves it unchanged.
- rst mid-operation: immediately aborts any stream or wait and empties both FIFOs; the Updater is reset by the same rst.

Optional Feature:
UPDQ_STATS_EN. When defined, it adds outputs:
- add_cnt[15:0]: increments on each accepted add_done, wraps at 16'hFFFF->0, cleared by rst.
- del_cnt[15:0]: increments on each accepted del_done, wraps at 16'hFFFF->0, cleared by rst.
- max_wait[15:0]: largest dispatch-to-done cycle count seen, saturating at 16'hFFFF.
When undefined, these ports and their logic are absent and all other behaviour is identical.

Test Plan:
- Single delete, pos={3'd2,3'd0,3'd0,3'd3,3'd1,3'd0} -> del_anchor 1-cycle pulse one cycle after accept; pos_encode stable until del_done; busy drops the cycle after del_done; q_level 1->0.
- Add with beats 10..18 pushed before the command -> add_anchor pulse with feature_in=10 in the same cycle, then 11..18 on 8 consecutive cycles; feature_in=0 afterward; wait for add_done.
- Add command first, beats trickled in 1 per 3 cycles -> no add_anchor until the 9th beat is stored; a following delete is not issued before that add.
- Push 4 deletes while the Updater withholds del_done -> cmd_ready=0 with q_level=3 plus 1 in flight and a 5th pushed; each del_done releases the next in order.
- Spurious add_done in IDLE, and a simultaneous add_done+del_done in WAIT_DEL -> proto_err=1 and sticky; state unaffected by the spurious done.
- Assert rst during ADD_STREAM beat 4 -> next cycle all outputs 0, q_level=0, state IDLE; a fresh add afterward streams from its own beat 0.

Source files
------------

// File: rtl/updater_cmd_queue_if.sv
// ---------------------------------------------------------------------------
// updater_cmd_queue_if
// Bundles the producer-side command/feature handshakes and the Updater-side
// pulse-start / stream / done signals of updater_cmd_queue.
//   slave  : the queue itself (accepts producer traffic, drives the Updater)
//   master : the environment (producer + Updater)
// Signals:
//   cmd_valid/cmd_ready/cmd_op/cmd_pos    producer command handshake
//   feat_valid/feat_ready/feat_data       producer feature-beat handshake
//   add_anchor/del_anchor                 one-cycle start pulses to Updater
//   pos_encode/feature_in                 position code and feature beat
//   add_done/del_done                     Updater completion strobes
//   busy/q_level/proto_err                status
//   add_cnt/del_cnt/max_wait              statistics (UPDQ_STATS_EN only)
// ---------------------------------------------------------------------------
interface updater_cmd_queue_if #(
    parameter int DATA_BUS_WIDTH    = 64,
    parameter int ENCODE_ADDR_WIDTH = 18,
    parameter int CMD_DEPTH         = 4
);
    localparam int QLW = $clog2(CMD_DEPTH + 1);

    logic                         cmd_valid;
    logic                         cmd_ready;
    logic                         cmd_op;
    logic [ENCODE_ADDR_WIDTH-1:0] cmd_pos;
    logic                         feat_valid;
    logic                         feat_ready;
    logic [DATA_BUS_WIDTH-1:0]    feat_data;
    logic                         add_anchor;
    logic                         del_anchor;
    logic [ENCODE_ADDR_WIDTH-1:0] pos_encode;
    logic [DATA_BUS_WIDTH-1:0]    feature_in;
    logic                         add_done;
    logic                         del_done;
    logic                         busy;
    logic [QLW-1:0]               q_level;
    logic                         proto_err;
`ifdef UPDQ_STATS_EN
    logic [15:0]                  add_cnt;
    logic [15:0]                  del_cnt;
    logic [15:0]                  max_wait;
`endif

    modport slave (
        input  cmd_valid, cmd_op, cmd_pos, feat_valid, feat_data, add_done, del_done,
        output cmd_ready, feat_ready, add_anchor, del_anchor, pos_encode, feature_in,
               busy, q_level, proto_err
`ifdef UPDQ_STATS_EN
        , output add_cnt, del_cnt, max_wait
`endif
    );

    modport master (
        output cmd_valid, cmd_op, cmd_pos, feat_valid, feat_data, add_done, del_done,
        input  cmd_ready, feat_ready, add_anchor, del_anchor, pos_encode, feature_in,
               busy, q_level, proto_err
`ifdef UPDQ_STATS_EN
        , input add_cnt, del_cnt, max_wait
`endif
    );
endinterface

// File: rtl/updater_cmd_queue.sv
// ---------------------------------------------------------------------------
// updater_cmd_queue
// Command FIFO + feature FIFO + dispatcher in front of the octree Updater.
// Requests are issued strictly in order, one at a time: a delete is a single
// del_anchor pulse, an add is an add_anchor pulse carrying beat 0 followed by
// FEATURE_LENTH-1 streamed beats. The dispatcher then waits for the matching
// done strobe before looking at the next command.
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset (also resets the Updater)
//   bus  updater_cmd_queue_if.slave (producer + Updater signals, status)
// Optional feature: define UPDQ_STATS_EN to add add_cnt/del_cnt/max_wait.
// ---------------------------------------------------------------------------
module updater_cmd_queue #(
    parameter int DATA_BUS_WIDTH    = 64,
    parameter int ENCODE_ADDR_WIDTH = 18,
    parameter int FEATURE_LENTH     = 9,
    parameter int CMD_DEPTH         = 4,
    parameter int FEAT_DEPTH        = CMD_DEPTH * FEATURE_LENTH
) (
    input  logic             clk,
    input  logic             rst,
    updater_cmd_queue_if.slave bus
);
    localparam int CMD_AW  = $clog2(CMD_DEPTH);
    localparam int CMD_CW  = $clog2(CMD_DEPTH + 1);
    localparam int FEAT_AW = (FEAT_DEPTH > 1) ? $clog2(FEAT_DEPTH) : 1;
    localparam int FEAT_CW = $clog2(FEAT_DEPTH + 1);
    localparam int BEAT_W  = $clog2(FEATURE_LENTH + 1);

    localparam logic [CMD_AW-1:0]  CMD_LAST  = CMD_AW'(CMD_DEPTH - 1);
    localparam logic [CMD_CW-1:0]  CMD_FULL  = CMD_CW'(CMD_DEPTH);
    localparam logic [FEAT_AW-1:0] FEAT_LAST = FEAT_AW'(FEAT_DEPTH - 1);
    localparam logic [FEAT_CW-1:0] FEAT_FULL = FEAT_CW'(FEAT_DEPTH);
    localparam logic [FEAT_CW-1:0] FEAT_NEED = FEAT_CW'(FEATURE_LENTH);
    localparam logic [BEAT_W-1:0]  BEAT_LAST = BEAT_W'(FEATURE_LENTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_ADD_STREAM, S_WAIT_ADD, S_WAIT_DEL} state_t;

    // Storage (no reset: contents are only meaningful below the count)
    logic [ENCODE_ADDR_WIDTH:0]   cmd_mem  [CMD_DEPTH];
    logic [DATA_BUS_WIDTH-1:0]    feat_mem [FEAT_DEPTH];

    logic [CMD_AW-1:0]            cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
    logic [CMD_CW-1:0]            cmd_cnt_q, cmd_cnt_d;
    logic [FEAT_AW-1:0]           feat_wr_q, feat_wr_d, feat_rd_q, feat_rd_d;
    logic [FEAT_CW-1:0]           feat_cnt_q, feat_cnt_d;
    state_t                       state_q, state_d;
    logic [BEAT_W-1:0]            beat_q, beat_d;
    logic [ENCODE_ADDR_WIDTH-1:0] pos_q, pos_d;
    logic                         proto_err_q, proto_err_d;

    logic                         cmd_ready, feat_ready, cmd_push, feat_push;
    logic                         head_op, dispatch, disp_add, disp_del, feat_pop;
    logic [ENCODE_ADDR_WIDTH-1:0] head_pos;
    logic                         add_ok, del_ok;

    // Ready is forced low while rst is held so nothing is admitted into a
    // FIFO that is being cleared.
    assign cmd_ready  = (cmd_cnt_q != CMD_FULL) && !rst;
    assign feat_ready = (feat_cnt_q != FEAT_FULL) && !rst;
    assign cmd_push   = bus.cmd_valid && cmd_ready;
    assign feat_push  = bus.feat_valid && feat_ready;

    assign head_op  = cmd_mem[cmd_rd_q][ENCODE_ADDR_WIDTH];
    assign head_pos = cmd_mem[cmd_rd_q][ENCODE_ADDR_WIDTH-1:0];

    // Dispatch is decided from registered FIFO state, so a command accepted
    // in one cycle can start the Updater in the very next one. An add only
    // goes once all its beats are buffered, which guarantees a bubble-free
    // stream.
    assign dispatch = (state_q == S_IDLE) && (cmd_cnt_q != '0) &&
                      (!head_op || (feat_cnt_q >= FEAT_NEED));
    assign disp_add = dispatch && head_op;
    assign disp_del = dispatch && !head_op;
    assign feat_pop = disp_add || (state_q == S_ADD_STREAM);

    // A done is accepted only alone and only in its matching wait state.
    assign add_ok = (state_q == S_WAIT_ADD) && bus.add_done && !bus.del_done;
    assign del_ok = (state_q == S_WAIT_DEL) && bus.del_done && !bus.add_done;

    always_comb begin
        cmd_wr_d    = cmd_wr_q;
        cmd_rd_d    = cmd_rd_q;
        cmd_cnt_d   = cmd_cnt_q;
        feat_wr_d   = feat_wr_q;
        feat_rd_d   = feat_rd_q;
        feat_cnt_d  = feat_cnt_q;
        state_d     = state_q;
        beat_d      = beat_q;
        pos_d       = pos_q;
        proto_err_d = proto_err_q;

        if (cmd_push) cmd_wr_d = (cmd_wr_q == CMD_LAST) ? '0 : cmd_wr_q + CMD_AW'(1);
        if (dispatch) cmd_rd_d = (cmd_rd_q == CMD_LAST) ? '0 : cmd_rd_q + CMD_AW'(1);
        case ({cmd_push, dispatch})
            2'b10:   cmd_cnt_d = cmd_cnt_q + CMD_CW'(1);
            2'b01:   cmd_cnt_d = cmd_cnt_q - CMD_CW'(1);
            default: cmd_cnt_d = cmd_cnt_q;
        endcase

        if (feat_push) feat_wr_d = (feat_wr_q == FEAT_LAST) ? '0 : feat_wr_q + FEAT_AW'(1);
        if (feat_pop)  feat_rd_d = (feat_rd_q == FEAT_LAST) ? '0 : feat_rd_q + FEAT_AW'(1);
        case ({feat_push, feat_pop})
            2'b10:   feat_cnt_d = feat_cnt_q + FEAT_CW'(1);
            2'b01:   feat_cnt_d = feat_cnt_q - FEAT_CW'(1);
            default: feat_cnt_d = feat_cnt_q;
        endcase

        if ((bus.add_done || bus.del_done) && !add_ok && !del_ok) proto_err_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (dispatch) begin
                    pos_d = head_pos;
                    if (head_op) begin
                        beat_d  = BEAT_W'(1);
                        state_d = (FEATURE_LENTH > 1) ? S_ADD_STREAM : S_WAIT_ADD;
                    end else begin
                        state_d = S_WAIT_DEL;
                    end
                end
            end
            S_ADD_STREAM: begin
                if (beat_q == BEAT_LAST) state_d = S_WAIT_ADD;
                else                     beat_d  = beat_q + BEAT_W'(1);
            end
            S_WAIT_ADD: if (add_ok) state_d = S_IDLE;
            S_WAIT_DEL: if (del_ok) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_wr_q    <= '0;
            cmd_rd_q    <= '0;
            cmd_cnt_q   <= '0;
            feat_wr_q   <= '0;
            feat_rd_q   <= '0;
            feat_cnt_q  <= '0;
            state_q     <= S_IDLE;
            beat_q      <= '0;
            pos_q       <= '0;
            proto_err_q <= 1'b0;
        end else begin
            cmd_wr_q    <= cmd_wr_d;
            cmd_rd_q    <= cmd_rd_d;
            cmd_cnt_q   <= cmd_cnt_d;
            feat_wr_q   <= feat_wr_d;
            feat_rd_q   <= feat_rd_d;
            feat_cnt_q  <= feat_cnt_d;
            state_q     <= state_d;
            beat_q      <= beat_d;
            pos_q       <= pos_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (cmd_push)  cmd_mem[cmd_wr_q]   <= {bus.cmd_op, bus.cmd_pos};
        if (feat_push) feat_mem[feat_wr_q] <= bus.feat_data;
    end

    assign bus.cmd_ready  = cmd_ready;
    assign bus.feat_ready = feat_ready;
    assign bus.add_anchor = disp_add;
    assign bus.del_anchor = disp_del;
    // The head position is shown in the dispatch cycle itself, then held.
    assign bus.pos_encode = dispatch ? head_pos : pos_q;
    assign bus.feature_in = feat_pop ? feat_mem[feat_rd_q] : '0;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.q_level    = cmd_cnt_q;
    assign bus.proto_err  = proto_err_q;

`ifdef UPDQ_STATS_EN
    logic [15:0] add_cnt_q, del_cnt_q, max_wait_q, wait_q;

    // wait_q counts cycles since the start pulse: 1 in the cycle after it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_cnt_q  <= '0;
            del_cnt_q  <= '0;
            max_wait_q <= '0;
            wait_q     <= '0;
        end else begin
            if (add_ok) add_cnt_q <= add_cnt_q + 16'd1;
            if (del_ok) del_cnt_q <= del_cnt_q + 16'd1;
            if (dispatch)                wait_q <= 16'd1;
            else if (wait_q != 16'hFFFF) wait_q <= wait_q + 16'd1;
            if ((add_ok || del_ok) && (wait_q > max_wait_q)) max_wait_q <= wait_q;
        end
    end

    assign bus.add_cnt  = add_cnt_q;
    assign bus.del_cnt  = del_cnt_q;
    assign bus.max_wait = max_wait_q;
`endif
endmodule
